// File: rtl/pwm_ctrl_pkg.sv
// Shared register offsets and FSM encoding for the PWM ramp sequencer.
// Imported by the sequencer top and its bench.
package pwm_ctrl_pkg;

    localparam logic [2:0] PWM_ADDR_MAX  = 3'b000;
    localparam logic [2:0] PWM_ADDR_THR  = 3'b010;
    localparam logic [2:0] PWM_ADDR_FLAG = 3'b100;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_PERIOD = 3'd2;
    localparam logic [2:0] REG_STEP   = 3'd4;
    localparam logic [2:0] REG_DWELL  = 3'd6;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_MAX  = 3'd1;
    localparam logic [2:0] ST_WR_THR0 = 3'd2;
    localparam logic [2:0] ST_WR_EN   = 3'd3;
    localparam logic [2:0] ST_DWELL   = 3'd4;
    localparam logic [2:0] ST_WR_THR  = 3'd5;
    localparam logic [2:0] ST_WR_DIS  = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_WR_MAX  = ST_WR_MAX,
        S_WR_THR0 = ST_WR_THR0,
        S_WR_EN   = ST_WR_EN,
        S_DWELL   = ST_DWELL,
        S_WR_THR  = ST_WR_THR,
        S_WR_DIS  = ST_WR_DIS
    } state_t;

endpackage

// File: rtl/pwm_ramp_step.sv
// One saturating ramp step: 17-bit arithmetic, clamped to [0, period].
// dir_down=0 ramps up; at_end flags that a ramp limit was reached.
module pwm_ramp_step (
    input  logic [15:0] thr,
    input  logic        dir_down,
    input  logic [15:0] step,
    input  logic [15:0] period,
    input  logic        loop_mode,
    output logic [15:0] next_thr,
    output logic        next_dir_down,
    output logic        at_end
);

    logic [16:0] step_eff;
    logic [16:0] sum;
    logic [16:0] diff;

    always_comb begin
        step_eff      = (step == 16'd0) ? 17'd1 : {1'b0, step};
        sum           = {1'b0, thr} + step_eff;
        diff          = {1'b0, thr} - step_eff;
        next_thr      = thr;
        next_dir_down = dir_down;
        at_end        = 1'b0;
        if (!dir_down) begin
            if (sum >= {1'b0, period}) begin
                next_thr      = period;
                next_dir_down = loop_mode;
                at_end        = 1'b1;
            end else begin
                next_thr = sum[15:0];
            end
        end else begin
            if ({1'b0, thr} <= step_eff) begin
                next_thr      = 16'd0;
                next_dir_down = 1'b0;
                at_end        = 1'b1;
            end else if (diff > {1'b0, period}) begin
                // period shrank while ramping down
                next_thr = period;
            end else begin
                next_thr = diff[15:0];
            end
        end
    end

endmodule

// File: rtl/pwm_ramp_sequencer.sv
// Autonomous PWM programmer: configures the PWM, then ramps its threshold
// up (one-shot) or up/down (loop) with a programmable dwell per step.
module pwm_ramp_sequencer
    import pwm_ctrl_pkg::*;
#(
    parameter logic [15:0] DEFAULT_PERIOD = 16'hFFFF,
    parameter logic [15:0] DEFAULT_STEP   = 16'h0100,
    parameter logic [15:0] DEFAULT_DWELL  = 16'd999
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_select,
    input  logic        cpu_write_enable,
    input  logic [2:0]  cpu_address,
    input  logic [15:0] cpu_write_data,
    output logic [15:0] cpu_read_data,
    output logic        pwm_select,
    output logic        pwm_write_enable,
    output logic [2:0]  pwm_address,
    output logic [15:0] pwm_write_data,
    output logic        busy,
    output logic        done
);

    state_t      state_q;
    state_t      state_d;
    logic        ctrl_en;
    logic        ctrl_loop;
    logic [15:0] period_q;
    logic [15:0] step_q;
    logic [15:0] dwell_q;
    logic [15:0] thr_q;
    logic        dir_q;
    logic        end_q;
    logic [15:0] cnt_q;
    logic        done_q;
    logic        sel_q;
    logic [15:0] read_q;
    logic [15:0] rdata;

    logic        cpu_wr;
    logic        cpu_rd;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        thr_load0;
    logic        thr_advance;
    logic        cnt_load;
    logic        cnt_dec;
    logic        set_done;

    logic [15:0] next_thr;
    logic        next_dir;
    logic        at_end;

    assign cpu_wr = cpu_select & cpu_write_enable;
    assign cpu_rd = cpu_select & ~cpu_write_enable;

    pwm_ramp_step u_step (
        .thr           (thr_q),
        .dir_down      (dir_q),
        .step          (step_q),
        .period        (period_q),
        .loop_mode     (ctrl_loop),
        .next_thr      (next_thr),
        .next_dir_down (next_dir),
        .at_end        (at_end)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_en       = 1'b0;
        wr_addr     = PWM_ADDR_MAX;
        wr_data     = 16'd0;
        thr_load0   = 1'b0;
        thr_advance = 1'b0;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        set_done    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // a finished one-shot waits for a fresh CTRL write
                if (ctrl_en && !done_q) state_d = S_WR_MAX;
            end
            S_WR_MAX: begin
                wr_en   = 1'b1;
                wr_addr = PWM_ADDR_MAX;
                wr_data = period_q;
                state_d = ctrl_en ? S_WR_THR0 : S_WR_DIS;
            end
            S_WR_THR0: begin
                wr_en     = 1'b1;
                wr_addr   = PWM_ADDR_THR;
                thr_load0 = 1'b1;
                state_d   = ctrl_en ? S_WR_EN : S_WR_DIS;
            end
            S_WR_EN: begin
                wr_en    = 1'b1;
                wr_addr  = PWM_ADDR_FLAG;
                wr_data  = 16'd1;
                cnt_load = 1'b1;
                state_d  = ctrl_en ? S_DWELL : S_WR_DIS;
            end
            S_DWELL: begin
                if (!ctrl_en) begin
                    state_d = S_WR_DIS;
                end else if (cnt_q == 16'd0) begin
                    thr_advance = 1'b1;
                    state_d     = S_WR_THR;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            S_WR_THR: begin
                wr_en   = 1'b1;
                wr_addr = PWM_ADDR_THR;
                wr_data = thr_q;
                if (!ctrl_en) begin
                    state_d = S_WR_DIS;
                end else if (!ctrl_loop && end_q) begin
                    set_done = 1'b1;
                    state_d  = S_WR_DIS;
                end else begin
                    cnt_load = 1'b1;
                    state_d  = S_DWELL;
                end
            end
            S_WR_DIS: begin
                wr_en   = 1'b1;
                wr_addr = PWM_ADDR_FLAG;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rdata = 16'd0;
        unique case (cpu_address)
            REG_CTRL:   rdata = {12'd0, done_q, busy, ctrl_loop, ctrl_en};
            REG_PERIOD: rdata = period_q;
            REG_STEP:   rdata = step_q;
            REG_DWELL:  rdata = dwell_q;
            default:    rdata = 16'd0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sel_q     <= 1'b0;
            ctrl_en   <= 1'b0;
            ctrl_loop <= 1'b0;
            period_q  <= DEFAULT_PERIOD;
            step_q    <= DEFAULT_STEP;
            dwell_q   <= DEFAULT_DWELL;
            thr_q     <= 16'd0;
            dir_q     <= 1'b0;
            end_q     <= 1'b0;
            cnt_q     <= 16'd0;
            done_q    <= 1'b0;
            read_q    <= 16'd0;
        end else begin
            sel_q <= 1'b1;
            if (cpu_wr) begin
                unique case (cpu_address)
                    REG_CTRL: begin
                        ctrl_en   <= cpu_write_data[0];
                        ctrl_loop <= cpu_write_data[1];
                    end
                    REG_PERIOD: period_q <= cpu_write_data;
                    REG_STEP:   step_q   <= cpu_write_data;
                    REG_DWELL:  dwell_q  <= cpu_write_data;
                    default: ;
                endcase
            end
            if (cpu_rd) read_q <= rdata;
            if (thr_load0) begin
                thr_q <= 16'd0;
                dir_q <= 1'b0;
                end_q <= 1'b0;
            end else if (thr_advance) begin
                thr_q <= next_thr;
                dir_q <= next_dir;
                end_q <= at_end & ~dir_q;
            end
            if (cnt_load) begin
                cnt_q <= dwell_q;
            end else if (cnt_dec) begin
                cnt_q <= cnt_q - 16'd1;
            end
            if (cpu_wr && cpu_address == REG_CTRL) begin
                done_q <= 1'b0;
            end else if (set_done) begin
                done_q <= 1'b1;
            end
        end
    end

    assign cpu_read_data    = read_q;
    assign pwm_select       = sel_q;
    assign pwm_write_enable = wr_en;
    assign pwm_address      = wr_addr;
    assign pwm_write_data   = wr_data;
    assign busy             = (state_q != S_IDLE);
    assign done             = done_q;

endmodule
